// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded control, operands, immediate and register specifiers.
// Latency: 1 cycle, registered outputs only, no combinational input-to-output path.
// Backpressure: stall_i holds the contents; flush_i or a low start_i loads a bubble; flush beats stall.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              MemRd_i,
  input  logic              MemWr_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              valid_i,
  output logic              ALUSrc_o,
  output logic              RegDst_o,
  output logic              MemRd_o,
  output logic              MemWr_o,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Whole stage slot kept as one packed word so a bubble is simply all zeros.
  typedef struct packed {
    logic              alu_src;
    logic              reg_dst;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_to_reg;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic              valid;
  } idex_t;

  idex_t slot_d;
  idex_t slot_q;
  logic  bubble;

  // A bubble is loaded on flush or while the core is not running.
  assign bubble = flush_i | ~start_i;

  // Gather the ID-side fields into the slot format; valid_i=0 loads unmasked.
  always_comb begin
    slot_d            = '0;
    slot_d.alu_src    = ALUSrc_i;
    slot_d.reg_dst    = RegDst_i;
    slot_d.mem_rd     = MemRd_i;
    slot_d.mem_wr     = MemWr_i;
    slot_d.mem_to_reg = MemtoReg_i;
    slot_d.reg_write  = RegWrite_i;
    slot_d.alu_op     = ALUOp_i;
    slot_d.pc4        = pc4_i;
    slot_d.rs_data    = rs_data_i;
    slot_d.rt_data    = rt_data_i;
    slot_d.imm        = imm_i;
    slot_d.rs_addr    = rs_addr_i;
    slot_d.rt_addr    = rt_addr_i;
    slot_d.rd_addr    = rd_addr_i;
    slot_d.valid      = valid_i;
  end

  // Slot register: bubble (zero everything, so no stale rd can forward) > hold > load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_q <= '0;
    end else if (bubble) begin
      slot_q <= '0;
    end else if (!stall_i) begin
      slot_q <= slot_d;
    end
  end

  // Debug counter of flush bubbles; idle cycles with start low are not counted, saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (flush_i && start_i && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

  assign ALUSrc_o   = slot_q.alu_src;
  assign RegDst_o   = slot_q.reg_dst;
  assign MemRd_o    = slot_q.mem_rd;
  assign MemWr_o    = slot_q.mem_wr;
  assign MemtoReg_o = slot_q.mem_to_reg;
  assign RegWrite_o = slot_q.reg_write;
  assign ALUOp_o    = slot_q.alu_op;
  assign pc4_o      = slot_q.pc4;
  assign rs_data_o  = slot_q.rs_data;
  assign rt_data_o  = slot_q.rt_data;
  assign imm_o      = slot_q.imm;
  assign rs_addr_o  = slot_q.rs_addr;
  assign rt_addr_o  = slot_q.rt_addr;
  assign rd_addr_o  = slot_q.rd_addr;
  assign valid_o    = slot_q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg, plus a CNT_W=4 instance for counter saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Each comparison goes through chk().
module tb_id_ex_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, flush_i;
  logic        ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] pc4_i, rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic        valid_i;

  logic        ALUSrc_o, RegDst_o, MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o;
  logic [15:0] bubble_cnt_o;

  logic        s_ALUSrc_o, s_RegDst_o, s_MemRd_o, s_MemWr_o, s_MemtoReg_o, s_RegWrite_o;
  logic [1:0]  s_ALUOp_o;
  logic [31:0] s_pc4_o, s_rs_data_o, s_rt_data_o, s_imm_o;
  logic [4:0]  s_rs_addr_o, s_rt_addr_o, s_rd_addr_o;
  logic        s_valid_o;
  logic [3:0]  s_bubble_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .MemRd_i(MemRd_i), .MemWr_i(MemWr_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .valid_i(valid_i),
    .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .MemRd_o(MemRd_o), .MemWr_o(MemWr_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ALUOp_o(ALUOp_o),
    .pc4_o(pc4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o), .valid_o(valid_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_reg #(.DATA_W(32), .CNT_W(4)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .MemRd_i(MemRd_i), .MemWr_i(MemWr_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .valid_i(valid_i),
    .ALUSrc_o(s_ALUSrc_o), .RegDst_o(s_RegDst_o), .MemRd_o(s_MemRd_o), .MemWr_o(s_MemWr_o),
    .MemtoReg_o(s_MemtoReg_o), .RegWrite_o(s_RegWrite_o), .ALUOp_o(s_ALUOp_o),
    .pc4_o(s_pc4_o), .rs_data_o(s_rs_data_o), .rt_data_o(s_rt_data_o), .imm_o(s_imm_o),
    .rs_addr_o(s_rs_addr_o), .rt_addr_o(s_rt_addr_o), .rd_addr_o(s_rd_addr_o), .valid_o(s_valid_o),
    .bubble_cnt_o(s_bubble_cnt_o)
  );

  // All main-instance stage outputs (excluding the counter) in one word.
  function automatic logic [151:0] all_out();
    return {ALUSrc_o, RegDst_o, MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o, ALUOp_o,
            pc4_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, valid_o};
  endfunction

  // Control bits as {ALUSrc,RegDst,MemRd,MemWr,MemtoReg,RegWrite,ALUOp[1:0]}.
  function automatic logic [7:0] ctrl_out();
    return {ALUSrc_o, RegDst_o, MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o, ALUOp_o};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    {ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i} = '0;
    ALUOp_i = 2'b00;
    pc4_i = '0; rs_data_i = '0; rt_data_i = '0; imm_i = '0;
    rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0;
    valid_i = 1'b0;
  endtask

  task automatic drive_sw();
    clear_inputs();
    ALUSrc_i = 1'b1; MemWr_i = 1'b1;
    rs_addr_i = 5'd4; rt_addr_i = 5'd9;
    rs_data_i = 32'h200; rt_data_i = 32'hABCD; imm_i = 32'h8;
    pc4_i = 32'h10C; valid_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    clear_inputs();

    // Reset held with random inputs and clock running.
    for (int i = 0; i < 3; i++) begin
      {ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i} = 6'($urandom);
      ALUOp_i = 2'($urandom); rs_data_i = $urandom; rt_data_i = $urandom;
      imm_i = $urandom; pc4_i = $urandom; rd_addr_i = 5'($urandom); valid_i = 1'b1;
      step();
    end
    chk("reset_outputs", 160'(all_out()), 160'd0);
    chk("reset_cnt", 160'(bubble_cnt_o), 160'd0);

    // Release reset between edges; lw goes in.
    rst_i = 1'b1;
    clear_inputs();
    ALUSrc_i = 1'b1; MemRd_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1;
    rs_data_i = 32'h10; imm_i = 32'h4; rt_addr_i = 5'd8; pc4_i = 32'h104; valid_i = 1'b1;
    #1;
    chk("no_comb_path_valid", 160'(valid_o), 160'd0);
    step();
    chk("lw_ctrl", 160'(ctrl_out()), 160'(8'b1010_1100));
    chk("lw_rs_data", 160'(rs_data_o), 160'h10);
    chk("lw_imm", 160'(imm_o), 160'h4);
    chk("lw_rt_addr", 160'(rt_addr_o), 160'd8);
    chk("lw_pc4", 160'(pc4_o), 160'h104);
    chk("lw_valid", 160'(valid_o), 160'd1);

    // R-type add, then a 3-cycle stall with sw waiting on the inputs.
    clear_inputs();
    RegDst_i = 1'b1; RegWrite_i = 1'b1; ALUOp_i = 2'b10;
    rs_addr_i = 5'd1; rt_addr_i = 5'd2; rd_addr_i = 5'd3;
    rs_data_i = 32'd5; rt_data_i = 32'd7; imm_i = 32'h0000_1820; pc4_i = 32'h108; valid_i = 1'b1;
    step();
    chk("add_ctrl", 160'(ctrl_out()), 160'(8'b0100_0110));
    chk("add_rd_addr", 160'(rd_addr_o), 160'd3);
    stall_i = 1'b1;
    drive_sw();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_ctrl", 160'(ctrl_out()), 160'(8'b0100_0110));
      chk("stall_hold_rt_data", 160'(rt_data_o), 160'd7);
      chk("stall_cnt", 160'(bubble_cnt_o), 160'd0);
    end
    stall_i = 1'b0;
    step();
    chk("sw_after_stall_ctrl", 160'(ctrl_out()), 160'(8'b1001_0000));
    chk("sw_after_stall_rt_data", 160'(rt_data_o), 160'hABCD);

    // Flush and stall together: bubble wins over hold.
    clear_inputs();
    RegWrite_i = 1'b1; ALUOp_i = 2'b11; rd_addr_i = 5'd5; rs_addr_i = 5'd6;
    rs_data_i = 32'h77; valid_i = 1'b1;
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    chk("flush_all_zero", 160'(all_out()), 160'd0);
    chk("flush_cnt", 160'(bubble_cnt_o), 160'd1);
    flush_i = 1'b0; stall_i = 1'b0;

    // Start gating: sw on the inputs for 5 idle cycles.
    drive_sw();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gated_memwr", 160'(MemWr_o), 160'd0);
      chk("gated_cnt", 160'(bubble_cnt_o), 160'd1);
    end
    start_i = 1'b1;
    step();
    chk("ungated_sw_ctrl", 160'(ctrl_out()), 160'(8'b1001_0000));
    chk("ungated_sw_valid", 160'(valid_o), 160'd1);

    // NoOp slot (valid_i=0) loads unmasked and is not counted.
    clear_inputs();
    rs_data_i = 32'h55; rd_addr_i = 5'd7; valid_i = 1'b0;
    step();
    chk("noop_rs_data", 160'(rs_data_o), 160'h55);
    chk("noop_rd_addr", 160'(rd_addr_o), 160'd7);
    chk("noop_valid", 160'(valid_o), 160'd0);
    chk("noop_cnt", 160'(bubble_cnt_o), 160'd1);

    // Asynchronous reset mid-cycle while stalled.
    stall_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    chk("async_reset_outputs", 160'(all_out()), 160'd0);
    chk("async_reset_cnt", 160'(bubble_cnt_o), 160'd0);
    #2 rst_i = 1'b1;
    stall_i = 1'b0;

    // 20 consecutive flushes: wide counter reaches 20, narrow one saturates at 15.
    flush_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_cnt_14", 160'(s_bubble_cnt_o), 160'd14);
      if (i == 15) chk("sat_cnt_15", 160'(s_bubble_cnt_o), 160'd15);
    end
    chk("sat_cnt_stays_15", 160'(s_bubble_cnt_o), 160'd15);
    chk("wide_cnt_20", 160'(bubble_cnt_o), 160'd20);
    flush_i = 1'b0;

    // Stall holds the counter.
    stall_i = 1'b1;
    step();
    chk("cnt_hold_on_stall", 160'(bubble_cnt_o), 160'd20);
    stall_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the decode control unit and register file, and upstream of the EX stage (ALU, ALU control, forwarding unit).
- Captures decoded control bits, operands, immediate and register addresses each cycle.
- Supports hold (stall), bubble insertion (flush) and start gating, and keeps a saturating count of injected bubbles for debug.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- CNT_W, 16, width of bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  core run enable; while low the stage loads bubbles
- stall_i  in  1  hold current contents (EX-side stall)
- flush_i  in  1  load a bubble instead of ID contents
- ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i  in  1 each  decoded control bits
- ALUOp_i  in  2  decoded ALU op class
- pc4_i  in  DATA_W  PC+4 of ID instruction
- rs_data_i, rt_data_i  in  DATA_W  register file read data
- imm_i  in  DATA_W  sign-extended immediate (funct in bits 5:0)
- rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  register specifiers
- valid_i  in  1  ID slot holds a real instruction
- ALUSrc_o, RegDst_o, MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALU op
- pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data
- rs_addr_o, rt_addr_o, rd_addr_o  out  5 each  registered specifiers
- valid_o  out  1  EX slot holds a real instruction
- bubble_cnt_o  out  CNT_W  saturating count of bubbles loaded

Behaviour:
- All outputs are registered; latency from input to output is 1 cycle. No combinational path from inputs to outputs.
- Reset (rst_i low, asynchronous): every output goes to 0, including bubble_cnt_o. Reset takes effect immediately, mid-stall or mid-flush; the first edge after deassertion is evaluated normally.
- Per rising edge, the first matching rule wins:
  1. Bubble condition (flush_i=1, or start_i=0):
     - Control outputs, ALUOp_o and valid_o go to 0.
     - Data and address fields also go to 0, so forwarding cannot match a stale rd.
  2. stall_i=1: all outputs hold their values.
  3. Otherwise: all fields load from their inputs, and valid_o <= valid_i.
- flush_i beats stall_i when both are high: a bubble is loaded, not held.
- Bubble masking is independent of the upstream NoOp masking. ALUOp_o is forced to 00 on a bubble even if ALUOp_i is nonzero. A bubble must never carry MemWr_o=1 or RegWrite_o=1.
- Rule-3 load with valid_i=0: fields load as given, with no masking. Upstream guarantees its control bits are 0 for a NoOp; no bubble count is taken.
- bubble_cnt_o:
  - Increments by 1 on each edge where rule 1 applies and start_i=1; start-gated idle cycles are not counted.
  - Saturates at all-ones and does not wrap.
  - Holds during stall.
- No other state.

Test Plan:
- Reset: hold rst_i=0 with random inputs and clock running -> all outputs 0 and bubble_cnt_o=0. Assert rst_i low between clock edges -> outputs clear without waiting for an edge.
- Normal load: start_i=1, inputs lw (ALUSrc=1, MemRd=1, MemtoReg=1, RegWrite=1, ALUOp=00), rs_data=0x10, imm=0x4, rt_addr=8 -> exactly one edge later the outputs match and valid_o=1.
- Stall: load R-type add (RegDst=1, RegWrite=1, ALUOp=10), then stall_i=1 for 3 cycles while inputs change to sw -> outputs stay add for 3 cycles, then load sw (MemWr_o=1).
- Flush priority: flush_i=1 and stall_i=1 in the same cycle with RegWrite_i=1, ALUOp_i=11 -> all control and address outputs 0, valid_o=0, bubble_cnt_o increments by 1.
- start gating: start_i=0 for 5 cycles with a sw on the inputs -> MemWr_o stays 0 and bubble_cnt_o is unchanged. After start_i=1 -> sw appears 1 cycle later.
- Saturation: CNT_W=4 with 20 consecutive flushes -> bubble_cnt_o reaches 15 and stays 15.
